// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM responder: command encodings, init states,
// err_flags bit indices, read-pipeline slot type and default geometry.
package sdram_pkg;

   localparam int DEF_ROW_WIDTH     = 13;
   localparam int DEF_COL_WIDTH     = 9;
   localparam int DEF_BANK_WIDTH    = 2;
   localparam int DEF_SDRADDR_WIDTH = 13;
   localparam int DEF_ROW_LO_BITS   = 2;
   localparam int DEF_TRCD          = 2;
   localparam int DEF_REFRESH_LIMIT = 520;

   // {ras_n, cas_n, we_n}
   typedef enum logic [2:0] {
      CMD_MRS  = 3'b000,
      CMD_REF  = 3'b001,
      CMD_PRE  = 3'b010,
      CMD_ACT  = 3'b011,
      CMD_WRIT = 3'b100,
      CMD_READ = 3'b101,
      CMD_NOP  = 3'b111
   } cmd_t;

   typedef enum logic [1:0] {
      WAIT_PRE,
      WAIT_REF,
      WAIT_MRS,
      READY
   } init_state_t;

   localparam int ERR_INIT     = 0;
   localparam int ERR_ACT_OPEN = 1;
   localparam int ERR_CLOSED   = 2;
   localparam int ERR_TRCD     = 3;
   localparam int ERR_REFRESH  = 4;

   typedef struct packed {
      logic        valid;
      logic [15:0] data;
   } rd_slot_t;

endpackage

// File: rtl/sdram_bank_tracker.sv
// Per-bank open flag, open row and ACT-to-access spacing counter.
// The spacing counters exist only when SDRAM_RESPONDER_TIMING_CHECK_EN is defined.
module sdram_bank_tracker
   import sdram_pkg::*;
#(
   parameter int BANK_WIDTH = DEF_BANK_WIDTH,
   parameter int ROW_WIDTH  = DEF_ROW_WIDTH,
   parameter int TRCD       = DEF_TRCD
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clock_enable,
   input  logic                  act,
   input  logic                  close_bank,
   input  logic                  close_all,
   input  logic [BANK_WIDTH-1:0] bank,
   input  logic [ROW_WIDTH-1:0]  row,
   output logic                  sel_open,
   output logic [ROW_WIDTH-1:0]  sel_row,
   output logic                  any_open,
   output logic                  trcd_short
);

   localparam int NB = 1 << BANK_WIDTH;

   logic [NB-1:0]        open_flags;
   logic [ROW_WIDTH-1:0] rows [NB];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         open_flags <= '0;
      end else if (clock_enable) begin
         if (close_all)
            open_flags <= '0;
         else if (close_bank)
            open_flags[bank] <= 1'b0;
         else if (act)
            open_flags[bank] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clock_enable && act)
         rows[bank] <= row;
   end

   assign sel_open = open_flags[bank];
   assign sel_row  = rows[bank];
   assign any_open = |open_flags;

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
   localparam int CW = $clog2(TRCD + 1);

   // Counts cycles since the last ACT per bank, saturating at TRCD.
   logic [CW-1:0] since_act [NB];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NB; i++)
            since_act[i] <= CW'(TRCD);
      end else if (clock_enable) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (act && bank == BANK_WIDTH'(i))
               since_act[i] <= CW'(1);
            else if (since_act[i] < CW'(TRCD))
               since_act[i] <= since_act[i] + 1'b1;
         end
      end
   end

   assign trcd_short = since_act[bank] < CW'(TRCD);
`else
   assign trcd_short = 1'b0;
`endif

endmodule

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device responder: init sequencing, bank state, backing store,
// CAS-latency read pipeline and sticky protocol error flags.
// Optional timing checks: SDRAM_RESPONDER_TIMING_CHECK_EN.
module sdram_responder
   import sdram_pkg::*;
#(
   parameter int ROW_WIDTH     = DEF_ROW_WIDTH,
   parameter int COL_WIDTH     = DEF_COL_WIDTH,
   parameter int BANK_WIDTH    = DEF_BANK_WIDTH,
   parameter int SDRADDR_WIDTH = DEF_SDRADDR_WIDTH,
   parameter int ROW_LO_BITS   = DEF_ROW_LO_BITS,
   parameter int TRCD          = DEF_TRCD,
   parameter int REFRESH_LIMIT = DEF_REFRESH_LIMIT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clock_enable,
   input  logic                     cs_n,
   input  logic                     ras_n,
   input  logic                     cas_n,
   input  logic                     we_n,
   input  logic [BANK_WIDTH-1:0]    bank_addr,
   input  logic [SDRADDR_WIDTH-1:0] addr,
   input  logic [15:0]              data_in,
   input  logic                     data_mask_low,
   input  logic                     data_mask_high,
   output logic [15:0]              data_out,
   output logic                     data_oe,
   output logic                     init_done,
   output logic [4:0]               err_flags
);

   localparam int IDX_W = BANK_WIDTH + ROW_LO_BITS + COL_WIDTH;
   localparam int DEPTH = 1 << IDX_W;

   init_state_t state, state_next;
   logic        ref_seen, init_err;
   logic [2:0]  cas_latency;
   logic [2:0]  pins;
   logic        active, ready, a10;
   logic        is_pre, is_ref, is_mrs, is_act, is_read, is_writ;
   logic        access, rd_ok, wr_ok, mrs_bad;
   logic        sel_open, any_open, trcd_short, ref_late;
   logic [ROW_WIDTH-1:0] sel_row;
   logic [IDX_W-1:0]     idx;
   logic [4:0]           err_set;
   logic [15:0]          mem [DEPTH];
   rd_slot_t             new_slot, pipe1, pipe2;

   assign active  = clock_enable & ~cs_n;
   assign pins    = {ras_n, cas_n, we_n};
   assign is_pre  = active && pins == CMD_PRE;
   assign is_ref  = active && pins == CMD_REF;
   assign is_mrs  = active && pins == CMD_MRS;
   assign is_act  = active && pins == CMD_ACT;
   assign is_read = active && pins == CMD_READ;
   assign is_writ = active && pins == CMD_WRIT;

   assign ready     = (state == READY);
   assign init_done = ready;
   assign a10       = addr[10];
   assign access    = ready & (is_read | is_writ);
   assign rd_ok     = ready & is_read & sel_open;
   assign wr_ok     = ready & is_writ & sel_open;
   assign mrs_bad   = is_mrs & (addr[6:4] != 3'd2) & (addr[6:4] != 3'd3);

   sdram_bank_tracker #(
      .BANK_WIDTH (BANK_WIDTH),
      .ROW_WIDTH  (ROW_WIDTH),
      .TRCD       (TRCD)
   ) u_tracker (
      .clk          (clk),
      .rst_n        (rst_n),
      .clock_enable (clock_enable),
      .act          (ready & is_act),
      .close_bank   ((ready & is_pre & ~a10) | ((rd_ok | wr_ok) & a10)),
      .close_all    (ready & is_pre & a10),
      .bank         (bank_addr),
      .row          (addr[ROW_WIDTH-1:0]),
      .sel_open     (sel_open),
      .sel_row      (sel_row),
      .any_open     (any_open),
      .trcd_short   (trcd_short)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= WAIT_PRE;
         ref_seen <= 1'b0;
      end else if (clock_enable) begin
         state <= state_next;
         if (state == WAIT_REF && is_ref)
            ref_seen <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      init_err   = 1'b0;
      unique case (state)
         WAIT_PRE: if (is_pre) begin
            if (a10) state_next = WAIT_REF;
            else     init_err   = 1'b1;
         end
         WAIT_REF: if (is_ref && ref_seen) state_next = WAIT_MRS;
         WAIT_MRS: if (is_mrs) state_next = READY;
         READY:    ;
      endcase
      if (!ready && (is_act || is_read || is_writ))
         init_err = 1'b1;
   end

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
   localparam int RW = $clog2(REFRESH_LIMIT + 2);
   logic [RW-1:0] ref_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         ref_cnt <= '0;
      else if (clock_enable && ready) begin
         if (is_ref)
            ref_cnt <= '0;
         else if (ref_cnt <= RW'(REFRESH_LIMIT))
            ref_cnt <= ref_cnt + 1'b1;
      end
   end

   assign ref_late = clock_enable & ready & ~is_ref & (ref_cnt >= RW'(REFRESH_LIMIT));
`else
   assign ref_late = 1'b0;
`endif

   always_comb begin
      err_set               = '0;
      err_set[ERR_INIT]     = init_err | mrs_bad;
      err_set[ERR_ACT_OPEN] = ready & is_act & sel_open;
      err_set[ERR_CLOSED]   = (access & ~sel_open) | (ready & is_ref & any_open);
      err_set[ERR_TRCD]     = access & trcd_short;
      err_set[ERR_REFRESH]  = ref_late;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_flags   <= '0;
         cas_latency <= 3'd3;
      end else if (clock_enable) begin
         err_flags <= err_flags | err_set;
         if (is_mrs && !mrs_bad)
            cas_latency <= addr[6:4];
      end
   end

   // Rows differing only above ROW_LO_BITS deliberately alias in the store.
   assign idx = {bank_addr, sel_row[ROW_LO_BITS-1:0], addr[COL_WIDTH-1:0]};

   always_ff @(posedge clk) begin
      if (rst_n && clock_enable && wr_ok) begin
         if (!data_mask_low)  mem[idx][7:0]  <= data_in[7:0];
         if (!data_mask_high) mem[idx][15:8] <= data_in[15:8];
      end
   end

   assign new_slot.valid = rd_ok & ~(data_mask_low & data_mask_high);
   assign new_slot.data  = mem[idx];

   // CL=3 enters one stage further back than CL=2; the output register is the last stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe1    <= '0;
         pipe2    <= '0;
         data_out <= '0;
         data_oe  <= 1'b0;
      end else if (clock_enable) begin
         data_oe  <= pipe1.valid;
         data_out <= pipe1.data;
         pipe1    <= pipe2;
         pipe2    <= '0;
         if (new_slot.valid) begin
            if (cas_latency == 3'd3) pipe2 <= new_slot;
            else                     pipe1 <= new_slot;
         end
      end
   end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed self-checking bench for sdram_responder; expectations for the
// optional timing checks follow SDRAM_RESPONDER_TIMING_CHECK_EN.
module tb_sdram_responder;

   localparam logic [2:0] C_MRS  = 3'b000;
   localparam logic [2:0] C_REF  = 3'b001;
   localparam logic [2:0] C_PRE  = 3'b010;
   localparam logic [2:0] C_ACT  = 3'b011;
   localparam logic [2:0] C_WRIT = 3'b100;
   localparam logic [2:0] C_READ = 3'b101;

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
   localparam logic TIMING = 1'b1;
`else
   localparam logic TIMING = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, clock_enable, cs_n, ras_n, cas_n, we_n;
   logic [1:0]  bank_addr;
   logic [12:0] addr;
   logic [15:0] data_in;
   logic        data_mask_low, data_mask_high;
   logic [15:0] data_out;
   logic        data_oe, init_done;
   logic [4:0]  err_flags;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sdram_responder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clock_enable   (clock_enable),
      .cs_n           (cs_n),
      .ras_n          (ras_n),
      .cas_n          (cas_n),
      .we_n           (we_n),
      .bank_addr      (bank_addr),
      .addr           (addr),
      .data_in        (data_in),
      .data_mask_low  (data_mask_low),
      .data_mask_high (data_mask_high),
      .data_out       (data_out),
      .data_oe        (data_oe),
      .init_done      (init_done),
      .err_flags      (err_flags)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      cs_n = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [15:0] d, input logic ml, input logic mh);
      cs_n = 1'b0;
      {ras_n, cas_n, we_n} = c;
      bank_addr = b;
      addr = a;
      data_in = d;
      data_mask_low = ml;
      data_mask_high = mh;
      @(posedge clk);
      #1;
      cs_n = 1'b1;
      {ras_n, cas_n, we_n} = 3'b111;
      data_mask_low = 1'b0;
      data_mask_high = 1'b0;
      data_in = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cs_n = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic do_init();
      step(C_PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
      step(C_REF, 2'd0, 13'h000, 16'h0, 1'b0, 1'b0);
      step(C_REF, 2'd0, 13'h000, 16'h0, 1'b0, 1'b0);
      step(C_MRS, 2'd0, 13'h230, 16'h0, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; clock_enable = 1'b1; cs_n = 1'b1;
      {ras_n, cas_n, we_n} = 3'b111;
      bank_addr = '0; addr = '0; data_in = '0;
      data_mask_low = 1'b0; data_mask_high = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_init_done", 32'(init_done), 32'd0);
      check("reset_err", 32'(err_flags), 32'd0);
      check("reset_oe", 32'(data_oe), 32'd0);
      check("reset_dout", 32'(data_out), 32'd0);
      rst_n = 1'b1;

      // ACT before init is a protocol error
      step(C_ACT, 2'd0, 13'h000, 16'h0, 1'b0, 1'b0);
      check("early_act_err", 32'(err_flags), 32'h01);
      do_reset();
      check("reset_clears_err", 32'(err_flags), 32'd0);

      step(C_PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
      check("init_after_pre", 32'(init_done), 32'd0);
      step(C_REF, 2'd0, 13'h000, 16'h0, 1'b0, 1'b0);
      step(C_REF, 2'd0, 13'h000, 16'h0, 1'b0, 1'b0);
      check("init_after_ref2", 32'(init_done), 32'd0);
      step(C_MRS, 2'd0, 13'h230, 16'h0, 1'b0, 1'b0);
      check("init_done", 32'(init_done), 32'd1);
      check("init_err", 32'(err_flags), 32'd0);

      // Write with auto-precharge, reopen, read back at CL=3
      step(C_ACT, 2'd1, 13'h0003, 16'h0, 1'b0, 1'b0);
      idle(1);
      step(C_WRIT, 2'd1, 13'h412, 16'hBEEF, 1'b0, 1'b0);
      step(C_ACT, 2'd1, 13'h0003, 16'h0, 1'b0, 1'b0);
      check("reopen_no_err", 32'(err_flags), 32'd0);
      idle(1);
      step(C_READ, 2'd1, 13'h012, 16'h0, 1'b0, 1'b0);
      check("cl3_oe_t1", 32'(data_oe), 32'd0);
      idle(1);
      check("cl3_oe_t2", 32'(data_oe), 32'd0);
      idle(1);
      check("cl3_oe_t3", 32'(data_oe), 32'd1);
      check("cl3_data", 32'(data_out), 32'hBEEF);
      idle(1);
      check("cl3_oe_t4", 32'(data_oe), 32'd0);

      // Masked high byte, read immediately after write
      step(C_WRIT, 2'd1, 13'h012, 16'h1234, 1'b0, 1'b1);
      step(C_READ, 2'd1, 13'h012, 16'h0, 1'b0, 1'b0);
      idle(2);
      check("mask_oe", 32'(data_oe), 32'd1);
      check("mask_data", 32'(data_out), 32'hBE34);

      // Clock enable low freezes an in-flight read
      step(C_READ, 2'd1, 13'h012, 16'h0, 1'b0, 1'b0);
      clock_enable = 1'b0;
      idle(3);
      check("freeze_oe", 32'(data_oe), 32'd0);
      clock_enable = 1'b1;
      idle(1);
      check("unfreeze_oe_t2", 32'(data_oe), 32'd0);
      idle(1);
      check("unfreeze_oe_t3", 32'(data_oe), 32'd1);
      check("unfreeze_data", 32'(data_out), 32'hBE34);
      check("freeze_err", 32'(err_flags), 32'd0);

      // CL=2, back-to-back reads
      step(C_MRS, 2'd0, 13'h020, 16'h0, 1'b0, 1'b0);
      step(C_WRIT, 2'd1, 13'h013, 16'hCAFE, 1'b0, 1'b0);
      step(C_READ, 2'd1, 13'h012, 16'h0, 1'b0, 1'b0);
      step(C_READ, 2'd1, 13'h013, 16'h0, 1'b0, 1'b0);
      check("b2b_oe1", 32'(data_oe), 32'd1);
      check("b2b_data1", 32'(data_out), 32'hBE34);
      idle(1);
      check("b2b_oe2", 32'(data_oe), 32'd1);
      check("b2b_data2", 32'(data_out), 32'hCAFE);
      idle(1);
      check("b2b_oe_end", 32'(data_oe), 32'd0);

      // Row 7 aliases row 3 in the backing store
      step(C_PRE, 2'd1, 13'h000, 16'h0, 1'b0, 1'b0);
      step(C_ACT, 2'd1, 13'h0007, 16'h0, 1'b0, 1'b0);
      idle(1);
      step(C_READ, 2'd1, 13'h012, 16'h0, 1'b0, 1'b0);
      idle(1);
      check("alias_oe", 32'(data_oe), 32'd1);
      check("alias_data", 32'(data_out), 32'hBE34);

      // Both masks on a read suppress data_oe
      step(C_READ, 2'd1, 13'h012, 16'h0, 1'b1, 1'b1);
      idle(1);
      check("masked_read_oe", 32'(data_oe), 32'd0);
      check("pre_closed_err", 32'(err_flags), 32'd0);

      // Read to closed bank 2
      step(C_PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
      step(C_READ, 2'd2, 13'h000, 16'h0, 1'b0, 1'b0);
      check("closed_err", 32'(err_flags), 32'h04);
      idle(1);
      check("closed_oe_t2", 32'(data_oe), 32'd0);
      idle(1);
      check("closed_oe_t3", 32'(data_oe), 32'd0);

      // ACT to an already-open bank
      step(C_ACT, 2'd3, 13'h0001, 16'h0, 1'b0, 1'b0);
      step(C_ACT, 2'd3, 13'h0002, 16'h0, 1'b0, 1'b0);
      check("act_open_err", 32'(err_flags), 32'h06);

      // tRCD violation
      do_reset();
      check("reset2_err", 32'(err_flags), 32'd0);
      do_init();
      step(C_ACT, 2'd0, 13'h0005, 16'h0, 1'b0, 1'b0);
      step(C_READ, 2'd0, 13'h000, 16'h0, 1'b0, 1'b0);
      check("trcd_err", 32'(err_flags), TIMING ? 32'h08 : 32'h00);

      // REF with a bank open
      step(C_REF, 2'd0, 13'h000, 16'h0, 1'b0, 1'b0);
      check("ref_open_err", 32'(err_flags), TIMING ? 32'h0C : 32'h04);

      // Reset mid-read cancels pending data (CL back to 3)
      do_reset();
      do_init();
      step(C_ACT, 2'd1, 13'h0003, 16'h0, 1'b0, 1'b0);
      idle(1);
      step(C_READ, 2'd1, 13'h012, 16'h0, 1'b0, 1'b0);
      do_reset();
      idle(1);
      check("reset_mid_read_oe", 32'(data_oe), 32'd0);
      idle(1);
      check("reset_mid_read_oe2", 32'(data_oe), 32'd0);

      // Refresh interval
      do_init();
      idle(400);
      check("refresh_ok", 32'(err_flags), 32'd0);
      idle(130);
      check("refresh_late", 32'(err_flags), TIMING ? 32'h10 : 32'h00);
      do_reset();
      check("final_reset_err", 32'(err_flags), 32'd0);
      check("final_reset_init", 32'(init_done), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
